id_ex_stage_reg: RTL
====================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline boundary, directly downstream of the opcode-decode control unit.
- Registers the decoded control bundle plus operand/address fields into EX.
- Detects load-use hazards, stalls PC and IF/ID, and inserts bubbles.
- Applies flush (taken branch/jump) and downstream hold with fixed priority.

Parameters:
- DATA_W, 32, width of register operands, immediate, PC+4.
- REG_ADDR_W, 5, register-file address width.
- ALU_OP_W, 3, width of alu_op control field.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- id_valid  in  1  ID holds a real instruction
- id_branch, id_reg_dst, id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg  in  1 each  control bits from control unit
- id_alu_op  in  ALU_OP_W  ALU operation class
- id_rs_data, id_rt_data, id_imm, id_pc_plus4  in  DATA_W  operands, sign-extended imm, PC+4
- id_rs, id_rt, id_rd  in  REG_ADDR_W  register addresses
- flush  in  1  squash the ID instruction (taken branch/jump)
- hold  in  1  downstream not ready; freeze EX stage
- stall  out  1  freeze PC and IF/ID this cycle (combinational)
- ex_valid  out  1  EX holds a real instruction
- ex_branch, ex_reg_dst, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  out  1 each  registered control bits
- ex_alu_op  out  ALU_OP_W  registered ALU op
- ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus4  out  DATA_W  registered data
- ex_rs, ex_rt, ex_rd  out  REG_ADDR_W  registered addresses

Behaviour:
- Reset (reset=0, async): ex_valid and all ex_* control bits 0; data/address outputs 0. Counters (if enabled) 0. Release is synchronous to next clk edge.
- id_uses_rt = id_reg_dst | id_mem_write | id_branch.
- hazard = id_valid & ex_valid & ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
- stall = ~flush & (hold | hazard), combinational, same cycle.
- Per rising edge, priority flush > hold > hazard > load:
  - flush: bubble (ex_valid=0, all control bits 0); data fields keep previous value.
  - hold: all ex_* and ex_valid retain value.
  - hazard: bubble as above; ID contents preserved upstream by stall.
  - else load: every ex_* <= id_*; ex_valid <= id_valid; if id_valid=0, control bits forced 0.
- Latency 1 cycle ID->EX; a load-use hazard costs exactly 1 bubble. Next cycle ex_mem_read=0, so hazard cannot repeat for the same pair.
- Address 0 never triggers a hazard.
- flush with hold: flush wins; EX is squashed even while held.
- Bubble data fields are don't-care; verification checks data only when ex_valid=1.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined: extra outputs stall_cnt and bubble_cnt (32 bits each), saturating at all-ones, cleared by reset.
  - stall_cnt increments every cycle stall=1.
  - bubble_cnt increments every edge a flush or hazard bubble is inserted.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package/header holds:
  - ALU_OP_W.
  - Control-bundle width (10) and bit-field positions for {alu_op, reg_dst, alu_src, branch, mem_read, mem_write, reg_write, mem_to_reg}.
  - Bubble constant (all zero).
- Sub-module hazard_detect: pure combinational compare producing hazard. Registers and priority mux stay in the top.

Test Plan:
- Reset mid-run: drive valid add, assert reset=0 between edges -> ex_valid=0 and ex_reg_write=0 immediately, without waiting for clk.
- Plain pass-through: R-type add, rs=1, rt=2, rd=3, rs_data=0x5, rt_data=0x7 -> next cycle ex_rs_data=0x5, ex_rd=3, ex_reg_write=1, stall=0.
- Load-use: lw to rt=8 in EX, then add rs=8 in ID -> stall=1 one cycle, one bubble (ex_valid=0), add enters EX on following edge; with PERF enabled, stall_cnt=1 and bubble_cnt=1.
- No false hazard:
  - lw rt=0 followed by use of r0 -> stall=0.
  - addi (id_uses_rt=0) with id_rt=8 after lw rt=8 -> stall=0.
- Flush beats hold/hazard: flush=1, hold=1 and hazard true simultaneously -> stall=0; after edge ex_valid=0 and all control bits 0.
- Hold: hold=1 for 3 cycles with changing ID inputs -> ex_* frozen, stall=1 each cycle; on release the pending ID instruction loads.

Source files
------------

// File: rtl/id_ex_stage_reg_pkg.sv
// Shared definitions for the ID/EX boundary: control-bundle layout, bubble value,
// and the "instruction reads rt" rule used by load-use detection.
package id_ex_stage_reg_pkg;

  localparam int ALU_OP_W = 3;
  localparam int CTRL_W   = ALU_OP_W + 7;

  // Bundle layout, MSB first: {alu_op, reg_dst, alu_src, branch, mem_read, mem_write, reg_write, mem_to_reg}
  localparam int CTRL_MEM_TO_REG_BIT = 0;
  localparam int CTRL_REG_WRITE_BIT  = 1;
  localparam int CTRL_MEM_WRITE_BIT  = 2;
  localparam int CTRL_MEM_READ_BIT   = 3;
  localparam int CTRL_BRANCH_BIT     = 4;
  localparam int CTRL_ALU_SRC_BIT    = 5;
  localparam int CTRL_REG_DST_BIT    = 6;
  localparam int CTRL_ALU_OP_LSB     = 7;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

  // R-type, store and branch instructions all consume the rt operand.
  function automatic logic uses_rt(input logic reg_dst, input logic mem_write,
                                   input logic branch);
    return reg_dst | mem_write | branch;
  endfunction

endpackage

// File: rtl/id_ex_stage_reg_hazard_detect.sv
// Load-use hazard compare: an EX load whose destination rt feeds the ID instruction.
// Purely combinational; register 0 is never a hazard source.
module id_ex_stage_reg_hazard_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  id_valid,
  input  logic                  id_reg_dst,
  input  logic                  id_mem_write,
  input  logic                  id_branch,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  output logic                  hazard
);
  import id_ex_stage_reg_pkg::*;

  logic id_uses_rt;
  logic rs_match;
  logic rt_match;
  logic ex_rt_nonzero;

  assign id_uses_rt    = uses_rt(id_reg_dst, id_mem_write, id_branch);
  assign rs_match      = (ex_rt == id_rs);
  assign rt_match      = (ex_rt == id_rt);
  assign ex_rt_nonzero = (ex_rt != '0);

  assign hazard = id_valid & ex_valid & ex_mem_read & ex_rt_nonzero &
                  (rs_match | (id_uses_rt & rt_match));

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use stall, flush and hold (priority flush > hold > hazard > load).
// Optional ID_EX_PERF_CNT_EN adds saturating stall_cnt / bubble_cnt outputs.
module id_ex_stage_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic                  id_branch,
  input  logic                  id_reg_dst,
  input  logic                  id_alu_src,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_reg_write,
  input  logic                  id_mem_to_reg,
  input  logic [ALU_OP_W-1:0]   id_alu_op,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [DATA_W-1:0]     id_pc_plus4,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  flush,
  input  logic                  hold,
  output logic                  stall,
  output logic                  ex_valid,
  output logic                  ex_branch,
  output logic                  ex_reg_dst,
  output logic                  ex_alu_src,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_reg_write,
  output logic                  ex_mem_to_reg,
  output logic [ALU_OP_W-1:0]   ex_alu_op,
  output logic [DATA_W-1:0]     ex_rs_data,
  output logic [DATA_W-1:0]     ex_rt_data,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [DATA_W-1:0]     ex_pc_plus4,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           bubble_cnt
`endif
);
  import id_ex_stage_reg_pkg::*;

  localparam int BUNDLE_W = ALU_OP_W + 7;
  localparam logic [BUNDLE_W-1:0] BUBBLE = BUNDLE_W'(CTRL_BUBBLE);

  logic                  hazard;
  logic                  bubble;
  logic                  load;
  logic [BUNDLE_W-1:0]   id_ctrl;
  logic [BUNDLE_W-1:0]   ctrl_reg;
  logic [BUNDLE_W-1:0]   ctrl_next;
  logic                  ex_valid_reg;
  logic                  ex_valid_next;
  logic [DATA_W-1:0]     rs_data_reg;
  logic [DATA_W-1:0]     rt_data_reg;
  logic [DATA_W-1:0]     imm_reg;
  logic [DATA_W-1:0]     pc_plus4_reg;
  logic [REG_ADDR_W-1:0] rs_reg;
  logic [REG_ADDR_W-1:0] rt_reg;
  logic [REG_ADDR_W-1:0] rd_reg;

  id_ex_stage_reg_hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_detect (
    .id_valid     (id_valid),
    .id_reg_dst   (id_reg_dst),
    .id_mem_write (id_mem_write),
    .id_branch    (id_branch),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_valid     (ex_valid_reg),
    .ex_mem_read  (ctrl_reg[CTRL_MEM_READ_BIT]),
    .ex_rt        (rt_reg),
    .hazard       (hazard)
  );

  always_comb begin
    id_ctrl = '0;
    id_ctrl[CTRL_ALU_OP_LSB +: ALU_OP_W] = id_alu_op;
    id_ctrl[CTRL_REG_DST_BIT]            = id_reg_dst;
    id_ctrl[CTRL_ALU_SRC_BIT]            = id_alu_src;
    id_ctrl[CTRL_BRANCH_BIT]             = id_branch;
    id_ctrl[CTRL_MEM_READ_BIT]           = id_mem_read;
    id_ctrl[CTRL_MEM_WRITE_BIT]          = id_mem_write;
    id_ctrl[CTRL_REG_WRITE_BIT]          = id_reg_write;
    id_ctrl[CTRL_MEM_TO_REG_BIT]         = id_mem_to_reg;
  end

  // A flush squashes EX even while held; a hazard bubble only happens when not held.
  assign stall  = ~flush & (hold | hazard);
  assign bubble = flush | (~hold & hazard);
  assign load   = ~flush & ~hold & ~hazard;

  always_comb begin
    ex_valid_next = ex_valid_reg;
    ctrl_next     = ctrl_reg;
    if (bubble) begin
      ex_valid_next = 1'b0;
      ctrl_next     = BUBBLE;
    end else if (load) begin
      ex_valid_next = id_valid;
      ctrl_next     = id_valid ? id_ctrl : BUBBLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_reg <= 1'b0;
      ctrl_reg     <= BUBBLE;
      rs_data_reg  <= '0;
      rt_data_reg  <= '0;
      imm_reg      <= '0;
      pc_plus4_reg <= '0;
      rs_reg       <= '0;
      rt_reg       <= '0;
      rd_reg       <= '0;
    end else begin
      ex_valid_reg <= ex_valid_next;
      ctrl_reg     <= ctrl_next;
      if (load) begin
        rs_data_reg  <= id_rs_data;
        rt_data_reg  <= id_rt_data;
        imm_reg      <= id_imm;
        pc_plus4_reg <= id_pc_plus4;
        rs_reg       <= id_rs;
        rt_reg       <= id_rt;
        rd_reg       <= id_rd;
      end
    end
  end

  assign ex_valid      = ex_valid_reg;
  assign ex_alu_op     = ctrl_reg[CTRL_ALU_OP_LSB +: ALU_OP_W];
  assign ex_reg_dst    = ctrl_reg[CTRL_REG_DST_BIT];
  assign ex_alu_src    = ctrl_reg[CTRL_ALU_SRC_BIT];
  assign ex_branch     = ctrl_reg[CTRL_BRANCH_BIT];
  assign ex_mem_read   = ctrl_reg[CTRL_MEM_READ_BIT];
  assign ex_mem_write  = ctrl_reg[CTRL_MEM_WRITE_BIT];
  assign ex_reg_write  = ctrl_reg[CTRL_REG_WRITE_BIT];
  assign ex_mem_to_reg = ctrl_reg[CTRL_MEM_TO_REG_BIT];
  assign ex_rs_data    = rs_data_reg;
  assign ex_rt_data    = rt_data_reg;
  assign ex_imm        = imm_reg;
  assign ex_pc_plus4   = pc_plus4_reg;
  assign ex_rs         = rs_reg;
  assign ex_rt         = rt_reg;
  assign ex_rd         = rd_reg;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] bubble_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_reg  <= '0;
      bubble_cnt_reg <= '0;
    end else begin
      if (stall && !(&stall_cnt_reg))
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if (bubble && !(&bubble_cnt_reg))
        bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt  = stall_cnt_reg;
  assign bubble_cnt = bubble_cnt_reg;
`endif

endmodule
